// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute sequencing, memory wait timeout, retired-instruction counter.
// Optional define MCCU_SUBWORD_EN adds LB/LH/SB/SH decoding with byte/half data_size.
module multicycle_control_unit #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic             illegal,
   output logic             timeout,
   output logic [1:0]       alu_src_b,
   output logic [5:0]       alu_func,
   output logic [1:0]       data_size,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
      MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB     = 4'd7, I_EXEC = 4'd8, I_WB   = 4'd9,
      ERR    = 4'd10
   } state_t;

   localparam logic [5:0] ALU_ADD   = 6'b100000;
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t           state_reg;
   logic [5:0]       opcode_reg;
   logic [5:0]       funct_reg;
   logic [7:0]       wait_cnt_reg;
   logic             timeout_reg;
   logic [CNT_W-1:0] instr_count_reg;
   logic [1:0]       access_size;
   logic             wait_expired;

   function automatic logic is_load(input logic [5:0] op);
`ifdef MCCU_SUBWORD_EN
      return (op == 6'b100011) || (op == 6'b100000) || (op == 6'b100001);
`else
      return op == 6'b100011;
`endif
   endfunction

   function automatic logic is_store(input logic [5:0] op);
`ifdef MCCU_SUBWORD_EN
      return (op == 6'b101011) || (op == 6'b101000) || (op == 6'b101001);
`else
      return op == 6'b101011;
`endif
   endfunction

   function automatic logic is_r_funct(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
   endfunction

`ifdef MCCU_SUBWORD_EN
   always_comb begin
      case (opcode_reg)
         6'b100000, 6'b101000: access_size = 2'b00;
         6'b100001, 6'b101001: access_size = 2'b01;
         default:              access_size = 2'b10;
      endcase
   end
`else
   assign access_size = 2'b10;
`endif

   // The current cycle is the MAX_WAIT-th consecutive not-ready cycle when this is set
   assign wait_expired = (wait_cnt_reg == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= FETCH;
         opcode_reg      <= '0;
         funct_reg       <= '0;
         wait_cnt_reg    <= '0;
         timeout_reg     <= 1'b0;
         instr_count_reg <= '0;
      end else begin
         timeout_reg  <= 1'b0;
         wait_cnt_reg <= '0;
         case (state_reg)
            FETCH: begin
               if (mem_ready) begin
                  state_reg <= DECODE;
               end else if (wait_expired) begin
                  state_reg   <= ERR;
                  timeout_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            DECODE: begin
               opcode_reg <= opcode;
               funct_reg  <= funct;
               if (opcode == 6'b000000)
                  state_reg <= is_r_funct(funct) ? R_EXEC : ERR;
               else if (opcode == 6'b001000)
                  state_reg <= I_EXEC;
               else if (is_load(opcode) || is_store(opcode))
                  state_reg <= MEM_ADDR;
               else
                  state_reg <= ERR;
            end
            MEM_ADDR: state_reg <= is_load(opcode_reg) ? MEM_RD : MEM_WR;
            MEM_RD: begin
               if (mem_ready) begin
                  state_reg <= MEM_WB;
               end else if (wait_expired) begin
                  state_reg   <= ERR;
                  timeout_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            MEM_WR: begin
               if (mem_ready) begin
                  state_reg       <= FETCH;
                  instr_count_reg <= instr_count_reg + CNT_W'(1);
               end else if (wait_expired) begin
                  state_reg   <= ERR;
                  timeout_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            MEM_WB, R_WB, I_WB: begin
               state_reg       <= FETCH;
               instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
            R_EXEC:  state_reg <= R_WB;
            I_EXEC:  state_reg <= I_WB;
            default: state_reg <= FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      illegal    = 1'b0;
      timeout    = 1'b0;
      alu_src_b  = 2'b00;
      alu_func   = ALU_ADD;
      data_size  = 2'b10;
      case (state_reg)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            data_size = access_size;
         end
         MEM_RD: begin
            mem_read  = 1'b1;
            i_or_d    = 1'b1;
            data_size = access_size;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            data_size  = access_size;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            data_size = access_size;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_func  = funct_reg;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_func  = funct_reg;
         end
         I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         I_WB:    reg_write = 1'b1;
         ERR: begin
            illegal = 1'b1;
            timeout = timeout_reg;
         end
         default: ;
      endcase
   end

   assign state       = state_reg;
   assign instr_count = instr_count_reg;

endmodule
